// File: rtl/scope_trigger_ctrl_pkg.sv
// Shared types and constants for the scope trigger/capture sequencer.
package scope_pkg;

  localparam int unsigned ADC_W = 12;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRETRIG = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_HOLD    = 3'd4,
    S_STOPPED = 3'd5
  } state_t;

  localparam logic [1:0] MODE_AUTO   = 2'b00;
  localparam logic [1:0] MODE_NORMAL = 2'b01;
  localparam logic [1:0] MODE_SINGLE = 2'b10;
  localparam logic [1:0] MODE_STOP   = 2'b11;

  function automatic logic is_write_state(state_t s);
    return (s == S_PRETRIG) || (s == S_ARMED) || (s == S_POST);
  endfunction

endpackage

// File: rtl/scope_trigger_ctrl_trig_detect.sv
// Edge trigger comparator with hysteresis: hf arms on an excursion past the
// hysteresis band, hit fires when the sample then crosses the level.
module trig_detect
  import scope_pkg::*;
#(
  parameter int unsigned HYST = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             valid,
  input  logic [ADC_W-1:0] sample,
  input  logic [ADC_W-1:0] level,
  input  logic             edge_sel,
  input  logic             clear,
  output logic             hit
);

  localparam logic [ADC_W-1:0] HYST_V = ADC_W'(HYST);
  localparam logic [ADC_W-1:0] MAX_V  = '1;

  logic             hf;
  logic [ADC_W-1:0] lo;
  logic [ADC_W-1:0] hi;
  logic             arm_cond;
  logic             fire_cond;

  // Band edges saturate so levels near 0 / full scale stay usable.
  always_comb begin
    lo = (level > HYST_V) ? level - HYST_V : '0;
    hi = (level > MAX_V - HYST_V) ? MAX_V : level + HYST_V;
    if (edge_sel) begin
      arm_cond  = sample > hi;
      fire_cond = sample <= level;
    end else begin
      arm_cond  = sample < lo;
      fire_cond = sample >= level;
    end
  end

  assign hit = valid && hf && fire_cond;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hf <= 1'b0;
    end else if (clear) begin
      hf <= 1'b0;
    end else if (valid && arm_cond) begin
      hf <= 1'b1;
    end
  end

endmodule

// File: rtl/scope_trigger_ctrl.sv
// Trigger and capture sequencer: circular pre-trigger fill, armed edge search,
// post-trigger fill, then a frozen frame handed to the display via ready/ack.
module scope_trigger_ctrl
  import scope_pkg::*;
#(
  parameter int unsigned DEPTH        = 640,
  parameter int unsigned PRE          = 160,
  parameter int unsigned HYST         = 16,
  parameter int unsigned AUTO_TIMEOUT = 4096,
  parameter int unsigned AW           = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] sample_data,
  input  logic [ADC_W-1:0] trig_level,
  input  logic             trig_edge,
  input  logic [1:0]       trig_mode,
  input  logic             force_trig,
  input  logic             rearm,
  input  logic             frame_ack,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [ADC_W-1:0] wr_data,
  output logic [AW-1:0]    frame_start,
  output logic             frame_ready,
  output logic             trig_auto,
  output logic [2:0]       state_out
);

  localparam int unsigned TW  = $clog2(AUTO_TIMEOUT + 1);
  localparam int unsigned AW1 = AW + 1;
  localparam logic [TW-1:0]  TO_MAX    = TW'(AUTO_TIMEOUT);
  localparam logic [AW-1:0]  PRE_M1    = AW'(PRE - 1);
  localparam logic [AW-1:0]  POST_M1   = AW'(DEPTH - PRE - 1);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW1-1:0] FS_OFS    = AW1'(DEPTH - PRE);
  localparam logic [AW1-1:0] DEPTH_V   = AW1'(DEPTH);
  localparam bit             POST_ONE  = (DEPTH - PRE == 1);

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic            wr_force;
  logic            force_pend;
  logic            timed_out;
  logic [AW-1:0]   wcnt;
  logic [TW-1:0]   to_cnt;
  logic            hit;
  logic            hf_en;
  logic            hf_clr;
  logic            trig;
  logic            pre_done;
  logic            post_done;
  logic [AW1-1:0]  fs_sum;
  logic [AW1-1:0]  fs_wrap;

  trig_detect #(
    .HYST (HYST)
  ) u_trig_detect (
    .clock    (clock),
    .reset_n  (reset_n),
    .valid    (hf_en),
    .sample   (wr_data),
    .level    (trig_level),
    .edge_sel (trig_edge),
    .clear    (hf_clr),
    .hit      (hit)
  );

  // Trigger and counter events are evaluated on the registered (being-written) sample.
  always_comb begin
    hf_en     = wr_en && ((state == S_PRETRIG) || (state == S_ARMED));
    timed_out = (trig_mode == MODE_AUTO) && (to_cnt == TO_MAX);
    trig      = wr_en && (state == S_ARMED) && (hit || wr_force) && (trig_mode != MODE_STOP);
    pre_done  = wr_en && (state == S_PRETRIG) && (wcnt == PRE_M1);
    post_done = wr_en && (state == S_POST) && (wcnt == POST_M1);
    fs_sum    = {1'b0, wr_addr} + FS_OFS;
    fs_wrap   = (fs_sum >= DEPTH_V) ? fs_sum - DEPTH_V : fs_sum;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    state_nxt = (trig_mode == MODE_STOP) ? S_STOPPED : S_PRETRIG;
      S_PRETRIG: begin
        if (trig_mode == MODE_STOP) state_nxt = S_STOPPED;
        else if (pre_done)          state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (trig_mode == MODE_STOP) state_nxt = S_STOPPED;
        else if (trig)              state_nxt = POST_ONE ? S_HOLD : S_POST;
      end
      S_POST:    if (post_done) state_nxt = S_HOLD;
      S_HOLD: begin
        if (frame_ack)
          state_nxt = ((trig_mode == MODE_SINGLE) || (trig_mode == MODE_STOP)) ? S_STOPPED : S_PRETRIG;
      end
      S_STOPPED: if (rearm && (trig_mode != MODE_STOP)) state_nxt = S_PRETRIG;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    state_out = state;
    // A sample whose write would land outside a capture state is dropped.
    accept    = sample_valid && is_write_state(state) && is_write_state(state_nxt);
    hf_clr    = trig || ((state != S_ARMED) && (state_nxt == S_ARMED));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_force    <= 1'b0;
      force_pend  <= 1'b0;
      wcnt        <= '0;
      to_cnt      <= '0;
      frame_start <= '0;
      frame_ready <= 1'b0;
      trig_auto   <= 1'b0;
    end else begin
      wr_en <= accept;
      if (accept) wr_data <= sample_data;
      if (wr_en) wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;

      // Forced/auto trigger is tagged onto the next accepted sample.
      wr_force   <= accept && (state == S_ARMED) && (force_pend || force_trig || timed_out);
      force_pend <= (state == S_ARMED) && (state_nxt == S_ARMED) && !accept
                    && (force_pend || force_trig);

      if (state != S_ARMED)                    to_cnt <= '0;
      else if (sample_valid && to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;

      unique case (state)
        S_PRETRIG: if (wr_en) wcnt <= pre_done ? '0 : wcnt + 1'b1;
        S_ARMED:   if (trig)  wcnt <= AW'(1);
        S_POST:    if (wr_en) wcnt <= wcnt + 1'b1;
        default:   wcnt <= '0;
      endcase

      if ((state != S_HOLD) && (state_nxt == S_HOLD))
        frame_ready <= 1'b1;
      else if (((state == S_HOLD) && frame_ack) || ((state == S_STOPPED) && (state_nxt == S_PRETRIG)))
        frame_ready <= 1'b0;

      if (trig) begin
        frame_start <= fs_wrap[AW-1:0];
        trig_auto   <= wr_force && !hit;
      end else if ((state == S_HOLD) && frame_ack) begin
        trig_auto <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scope_trigger_ctrl.sv
// Directed bench for scope_trigger_ctrl with a write scoreboard.
module tb_scope_trigger_ctrl;
  import scope_pkg::*;

  localparam int unsigned DEPTH = 16, PRE = 4, HYST = 2, AUTO_TIMEOUT = 8, AW = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          sample_valid;
  logic [11:0]   sample_data;
  logic [11:0]   trig_level;
  logic          trig_edge;
  logic [1:0]    trig_mode;
  logic          force_trig;
  logic          rearm;
  logic          frame_ack;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic [AW-1:0] frame_start;
  logic          frame_ready;
  logic          trig_auto;
  logic [2:0]    state_out;

  int tests = 0;
  int fails = 0;
  logic [AW+11:0] exp_q[$];
  logic [AW+11:0] exp_e;
  logic [AW-1:0]  model_addr;

  always #5 clock = ~clock;

  scope_trigger_ctrl #(
    .DEPTH(DEPTH), .PRE(PRE), .HYST(HYST), .AUTO_TIMEOUT(AUTO_TIMEOUT), .AW(AW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .trig_level(trig_level), .trig_edge(trig_edge), .trig_mode(trig_mode),
    .force_trig(force_trig), .rearm(rearm), .frame_ack(frame_ack),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_start(frame_start),
    .frame_ready(frame_ready), .trig_auto(trig_auto), .state_out(state_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input state_t s);
    chk(tag, 32'(state_out), 32'(s));
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [11:0] s, input bit exp_wr);
    sample_valid = 1'b1;
    sample_data  = s;
    if (exp_wr) begin
      exp_q.push_back({model_addr, s});
      model_addr = (model_addr == AW'(DEPTH - 1)) ? '0 : model_addr + 1'b1;
    end
    cyc();
    sample_valid = 1'b0;
    cyc();
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1; cyc(); rearm = 1'b0;
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1 && wr_en === 1'b1) begin
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(exp_e[AW+11:12]));
        chk("wr_data", 32'(wr_data), 32'(exp_e[11:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; sample_valid = 1'b0; sample_data = '0; trig_level = 12'd100;
    trig_edge = 1'b0; trig_mode = MODE_NORMAL; force_trig = 1'b0; rearm = 1'b0;
    frame_ack = 1'b0; model_addr = '0;
    cyc(); cyc(); cyc();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_frame_ready", 32'(frame_ready), 0);
    chk("rst_trig_auto", 32'(trig_auto), 0);
    chk_state("rst_state", S_IDLE);
    reset_n = 1'b1;
    cyc();
    chk_state("t1_pretrig", S_PRETRIG);

    // 1: normal rising ramp
    for (int i = 0; i < 4; i++) send(12'(i * 10), 1'b1);
    chk_state("t1_armed", S_ARMED);
    for (int i = 4; i < 10; i++) send(12'(i * 10), 1'b1);
    chk_state("t1_still_armed", S_ARMED);
    send(12'd100, 1'b1);
    chk_state("t1_post", S_POST);
    chk("t1_frame_start", 32'(frame_start), 6);
    for (int i = 11; i < 21; i++) send(12'(i * 10), 1'b1);
    chk("t1_not_ready_yet", 32'(frame_ready), 0);
    send(12'd210, 1'b1);
    chk("t1_frame_ready", 32'(frame_ready), 1);
    chk_state("t1_hold", S_HOLD);
    chk("t1_trig_auto", 32'(trig_auto), 0);
    chk("t1_sb_empty", 32'(exp_q.size()), 0);
    send(12'd500, 1'b0);
    send(12'd500, 1'b0);
    chk_state("t1_hold_kept", S_HOLD);
    trig_edge = 1'b1;
    pulse_ack();
    chk_state("t1_ack_pretrig", S_PRETRIG);
    chk("t1_ack_ready", 32'(frame_ready), 0);

    // 2: falling edge
    for (int i = 0; i < 4; i++) send(12'd50, 1'b1);
    chk_state("t2_armed", S_ARMED);
    send(12'd100, 1'b1);
    send(12'd101, 1'b1);
    chk_state("t2_no_trig_no_hf", S_ARMED);
    send(12'd200, 1'b1);
    send(12'd150, 1'b1);
    chk_state("t2_armed_150", S_ARMED);
    send(12'd99, 1'b1);
    chk_state("t2_post", S_POST);
    chk("t2_frame_start", 32'(frame_start), 10);
    for (int i = 0; i < 11; i++) send(12'd700, 1'b1);
    chk_state("t2_hold", S_HOLD);
    chk("t2_frame_ready", 32'(frame_ready), 1);
    chk("t2_trig_auto", 32'(trig_auto), 0);
    trig_mode = MODE_AUTO;
    trig_edge = 1'b0;
    pulse_ack();
    chk_state("t2_ack_pretrig", S_PRETRIG);

    // 3: auto timeout with flat input
    for (int i = 0; i < 4; i++) send(12'd50, 1'b1);
    chk_state("t3_armed", S_ARMED);
    for (int i = 0; i < 8; i++) send(12'd50, 1'b1);
    chk_state("t3_armed_after8", S_ARMED);
    send(12'd50, 1'b1);
    chk_state("t3_post", S_POST);
    chk("t3_trig_auto", 32'(trig_auto), 1);
    chk("t3_frame_start", 32'(frame_start), 2);
    for (int i = 0; i < 11; i++) send(12'd50, 1'b1);
    chk_state("t3_hold", S_HOLD);
    chk("t3_frame_ready", 32'(frame_ready), 1);
    chk("t3_trig_auto_held", 32'(trig_auto), 1);

    // 4: single mode goes to STOPPED on ack
    trig_mode = MODE_SINGLE;
    pulse_ack();
    chk_state("t4_stopped", S_STOPPED);
    chk("t4_frame_ready", 32'(frame_ready), 0);
    chk("t4_trig_auto", 32'(trig_auto), 0);
    for (int i = 0; i < 20; i++) send(12'd123, 1'b0);
    chk_state("t4_still_stopped", S_STOPPED);
    pulse_rearm();
    chk_state("t4_rearm_pretrig", S_PRETRIG);

    // 5: stop while armed
    for (int i = 0; i < 4; i++) send(12'd50, 1'b1);
    chk_state("t5_armed", S_ARMED);
    send(12'd50, 1'b1);
    send(12'd50, 1'b1);
    trig_mode = MODE_STOP;
    cyc();
    chk_state("t5_stopped", S_STOPPED);
    for (int i = 0; i < 5; i++) send(12'd200, 1'b0);
    pulse_rearm();
    chk_state("t5_rearm_ignored", S_STOPPED);

    // 6: reset during POST, then pulses in IDLE
    trig_mode = MODE_NORMAL;
    pulse_rearm();
    chk_state("t6_pretrig", S_PRETRIG);
    for (int i = 0; i < 4; i++) send(12'd50, 1'b1);
    send(12'd50, 1'b1);
    send(12'd150, 1'b1);
    chk_state("t6_post", S_POST);
    chk("t6_frame_start", 32'(frame_start), 9);
    send(12'd160, 1'b1);
    send(12'd170, 1'b1);
    reset_n = 1'b0;
    cyc();
    chk_state("t6_rst_state", S_IDLE);
    chk("t6_rst_wr_en", 32'(wr_en), 0);
    chk("t6_rst_wr_addr", 32'(wr_addr), 0);
    chk("t6_rst_wr_data", 32'(wr_data), 0);
    chk("t6_rst_frame_start", 32'(frame_start), 0);
    chk("t6_rst_frame_ready", 32'(frame_ready), 0);
    chk("t6_rst_trig_auto", 32'(trig_auto), 0);
    chk("t6_sb_empty", 32'(exp_q.size()), 0);
    model_addr = '0;
    reset_n = 1'b1;
    force_trig = 1'b1;
    frame_ack = 1'b1;
    cyc();
    force_trig = 1'b0;
    frame_ack = 1'b0;
    chk_state("t6_idle_exit", S_PRETRIG);
    chk("t6_idle_ready", 32'(frame_ready), 0);
    for (int i = 0; i < 4; i++) send(12'd150, 1'b1);
    send(12'd150, 1'b1);
    send(12'd150, 1'b1);
    chk_state("t6_no_force", S_ARMED);
    chk("t6_no_auto", 32'(trig_auto), 0);
    cyc();
    chk("final_sb_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
